// File: rtl/triangule_area_pkg.sv
// Shared widths and FSM state encoding for the doubled-triangle-area block.
package triangule_area_pkg;

    localparam int COORD_W = 11;
    localparam int AREA_W  = 24;
    localparam int DIFF_W  = 12;
    localparam int PROD_W  = 23;
    localparam int SUM_W   = 25;

    typedef enum logic [2:0] {
        ST_DONE = 3'd0,
        ST_LOAD = 3'd1,
        ST_DIFF = 3'd2,
        ST_MUL  = 3'd3,
        ST_SUM  = 3'd4,
        ST_ABS  = 3'd5
    } state_e;

endpackage

// File: rtl/triangule_area_term.sv
// One cross-product term x*(ya-yb): registered difference, then registered product.
module triangule_area_term
    import triangule_area_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      diff_en,
    input  logic                      mul_en,
    input  logic signed [COORD_W-1:0] x,
    input  logic signed [COORD_W-1:0] ya,
    input  logic signed [COORD_W-1:0] yb,
    output logic signed [PROD_W-1:0]  prod
);

    logic signed [DIFF_W-1:0] diff_d, diff_q;
    logic signed [PROD_W-1:0] prod_d, prod_q;
    logic signed [PROD_W-1:0] x_ext, diff_ext;

    // Difference in DIFF, product in MUL; both hold otherwise.
    always_comb begin
        diff_d   = diff_q;
        prod_d   = prod_q;
        x_ext    = PROD_W'(x);
        diff_ext = PROD_W'(diff_q);
        if (diff_en) begin
            diff_d = $signed({ya[COORD_W-1], ya}) - $signed({yb[COORD_W-1], yb});
        end
        if (mul_en) begin
            prod_d = x_ext * diff_ext;
        end
    end

    // Term registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            diff_q <= '0;
            prod_q <= '0;
        end else begin
            diff_q <= diff_d;
            prod_q <= prod_d;
        end
    end

    assign prod = prod_q;

endmodule

// File: rtl/triangule_area.sv
// Doubled triangle area |x1(y2-y3)+x2(y3-y1)+x3(y1-y2)| over a free-running
// 6-cycle frame. Define TRIANGULE_AREA_SIGNED_EN to output the signed sum
// (positive for counter-clockwise vertex order) instead of its magnitude.
module triangule_area
    import triangule_area_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic signed [COORD_W-1:0] a1x,
    input  logic signed [COORD_W-1:0] a1y,
    input  logic signed [COORD_W-1:0] a2x,
    input  logic signed [COORD_W-1:0] a2y,
    input  logic signed [COORD_W-1:0] a3x,
    input  logic signed [COORD_W-1:0] a3y,
    output logic signed [AREA_W-1:0]  area,
    output logic                      write
);

    state_e state_d, state_q;
    logic   write_d, write_q;

    logic signed [COORD_W-1:0] x1_d, x1_q, y1_d, y1_q;
    logic signed [COORD_W-1:0] x2_d, x2_q, y2_d, y2_q;
    logic signed [COORD_W-1:0] x3_d, x3_q, y3_d, y3_q;

    logic signed [PROD_W-1:0] p1, p2, p3;
    logic signed [SUM_W-1:0]  s_d, s_q, res;
    logic signed [AREA_W-1:0] area_d, area_q;

    logic load_en, diff_en, mul_en, sum_en, abs_en;

    assign load_en = (state_q == ST_LOAD);
    assign diff_en = (state_q == ST_DIFF);
    assign mul_en  = (state_q == ST_MUL);
    assign sum_en  = (state_q == ST_SUM);
    assign abs_en  = (state_q == ST_ABS);

    // Fixed state sequence; write is registered so it is high during DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_DONE: state_d = ST_LOAD;
            ST_LOAD: state_d = ST_DIFF;
            ST_DIFF: state_d = ST_MUL;
            ST_MUL:  state_d = ST_SUM;
            ST_SUM:  state_d = ST_ABS;
            ST_ABS:  state_d = ST_DONE;
            default: state_d = ST_DONE;
        endcase
        write_d = (state_d == ST_DONE);
    end

    // Operand capture happens only in LOAD; inputs are ignored elsewhere.
    always_comb begin
        x1_d = x1_q; y1_d = y1_q;
        x2_d = x2_q; y2_d = y2_q;
        x3_d = x3_q; y3_d = y3_q;
        if (load_en) begin
            x1_d = a1x; y1_d = a1y;
            x2_d = a2x; y2_d = a2y;
            x3_d = a3x; y3_d = a3y;
        end
    end

    triangule_area_term u_term1 (
        .clk(clk), .rst(rst), .diff_en(diff_en), .mul_en(mul_en),
        .x(x1_q), .ya(y2_q), .yb(y3_q), .prod(p1)
    );
    triangule_area_term u_term2 (
        .clk(clk), .rst(rst), .diff_en(diff_en), .mul_en(mul_en),
        .x(x2_q), .ya(y3_q), .yb(y1_q), .prod(p2)
    );
    triangule_area_term u_term3 (
        .clk(clk), .rst(rst), .diff_en(diff_en), .mul_en(mul_en),
        .x(x3_q), .ya(y1_q), .yb(y2_q), .prod(p3)
    );

    // Sum in SUM; magnitude (or signed pass-through) lands in area during ABS.
    always_comb begin
        s_d = s_q;
        if (sum_en) begin
            s_d = SUM_W'(p1) + SUM_W'(p2) + SUM_W'(p3);
        end
`ifdef TRIANGULE_AREA_SIGNED_EN
        res = s_q;
`else
        res = s_q[SUM_W-1] ? -s_q : s_q;
`endif
        area_d = area_q;
        if (abs_en) begin
            area_d = res[AREA_W-1:0];
        end
    end

    // All state registers; reset returns to DONE with write high and area cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_DONE;
            write_q <= 1'b1;
            x1_q    <= '0; y1_q <= '0;
            x2_q    <= '0; y2_q <= '0;
            x3_q    <= '0; y3_q <= '0;
            s_q     <= '0;
            area_q  <= '0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            x1_q    <= x1_d; y1_q <= y1_d;
            x2_q    <= x2_d; y2_q <= y2_d;
            x3_q    <= x3_d; y3_q <= y3_d;
            s_q     <= s_d;
            area_q  <= area_d;
        end
    end

    assign area  = area_q;
    assign write = write_q;

endmodule

// File: tb/tb_triangule_area.sv
// Self-checking bench for triangule_area: directed table, point-in-triangle
// sums, mid-frame reset, and randomized frames against an arithmetic model.
module tb_triangule_area;

    logic               clk;
    logic               rst;
    logic signed [10:0] a1x, a1y, a2x, a2y, a3x, a3y;
    logic signed [23:0] area;
    logic               write;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int    x1, y1, x2, y2, x3, y3;
        int    exp;
        string name;
    } vec_t;

`ifdef TRIANGULE_AREA_SIGNED_EN
    localparam int CW_EXP      = -12;
    localparam int OUT_PBC_EXP = -300;
    localparam int OUT_SUM_EXP = 100;
`else
    localparam int CW_EXP      = 12;
    localparam int OUT_PBC_EXP = 300;
    localparam int OUT_SUM_EXP = 700;
`endif

    triangule_area dut (
        .clk(clk), .rst(rst),
        .a1x(a1x), .a1y(a1y), .a2x(a2x), .a2y(a2y), .a3x(a3x), .a3y(a3y),
        .area(area), .write(write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    function automatic int ref_area(input int x1, y1, x2, y2, x3, y3);
        int s;
        s = x1 * (y2 - y3) + x2 * (y3 - y1) + x3 * (y1 - y2);
`ifdef TRIANGULE_AREA_SIGNED_EN
        return s;
`else
        return (s < 0) ? -s : s;
`endif
    endfunction

    function automatic int rnd_coord();
        logic signed [10:0] r;
        r = 11'($urandom);
        return int'(r);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic scramble();
        a1x = 11'($urandom); a1y = 11'($urandom);
        a2x = 11'($urandom); a2y = 11'($urandom);
        a3x = 11'($urandom); a3y = 11'($urandom);
    endtask

    task automatic drive(input vec_t v);
        a1x = 11'(v.x1); a1y = 11'(v.y1);
        a2x = 11'(v.x2); a2y = 11'(v.y2);
        a3x = 11'(v.x3); a3y = 11'(v.y3);
    endtask

    // Advance (bounded) to a negedge where write is high.
    task automatic wait_write(input string name);
        int n;
        n = 0;
        while (write !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, " request"}, int'(write === 1'b1), 1);
    endtask

    // One full frame: present operands during DONE, scramble them after LOAD,
    // then expect the result with the next write pulse 6 cycles later.
    task automatic run_frame(input vec_t v, output int got);
        int n;
        int held;
        bit hold_ok;
        wait_write(v.name);
        drive(v);
        held    = int'(area);
        hold_ok = 1'b1;
        n       = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 2) scramble();
            if (write !== 1'b1 && int'(area) != held) hold_ok = 1'b0;
        end while (write !== 1'b1 && n < 20);
        check({v.name, " latency"}, n, 6);
        check({v.name, " hold"}, int'(hold_ok), 1);
        got = int'(area);
        check({v.name, " area"}, got, v.exp);
    endtask

    vec_t tbl[8];
    vec_t pit[7];

    initial begin
        int got;
        int sum_in, sum_out;
        vec_t v;

        tbl[0] = '{0, 0, 4, 0, 0, 3, 12, "ccw"};
        tbl[1] = '{0, 0, 0, 3, 4, 0, CW_EXP, "cw"};
        tbl[2] = '{1, 1, 2, 2, 5, 5, 0, "collinear"};
        tbl[3] = '{-7, 3, -7, 3, -7, 3, 0, "identical"};
        tbl[4] = '{-1024, -1024, 1023, -1024, -1024, 1023, 4190209, "extreme"};
        tbl[5] = '{0, 0, 4, 0, 0, 3, 12, "ccw_again"};
        tbl[6] = '{-1024, 1023, -1024, -1024, 1023, -1024, 4190209, "extreme_rot"};
        tbl[7] = '{3, -5, -2, 7, 9, 1, 0, "mixed"};
        tbl[7].exp = 3 * (7 - 1) + (-2) * (1 + 5) + 9 * (-5 - 7);
`ifndef TRIANGULE_AREA_SIGNED_EN
        tbl[7].exp = (tbl[7].exp < 0) ? -tbl[7].exp : tbl[7].exp;
`endif

        pit[0] = '{0, 0, 10, 0, 0, 10, 100, "tri"};
        pit[1] = '{2, 2, 10, 0, 0, 10, 60, "in_pbc"};
        pit[2] = '{0, 0, 2, 2, 0, 10, 20, "in_apc"};
        pit[3] = '{0, 0, 10, 0, 2, 2, 20, "in_abp"};
        pit[4] = '{20, 20, 10, 0, 0, 10, OUT_PBC_EXP, "out_pbc"};
        pit[5] = '{0, 0, 20, 20, 0, 10, 200, "out_apc"};
        pit[6] = '{0, 0, 10, 0, 20, 20, 200, "out_abp"};

        rst = 1'b1;
        scramble();
        repeat (3) begin
            @(negedge clk);
            check("reset write", int'(write), 1);
            check("reset area", int'(area), 0);
            scramble();
        end
        rst = 1'b0;

        foreach (tbl[i]) run_frame(tbl[i], got);

        // Point-in-triangle: triangle then sub-triangles, back to back.
        run_frame(pit[0], got);
        check("pit triangle", got, 100);
        sum_in = 0;
        for (int i = 1; i <= 3; i++) begin
            run_frame(pit[i], got);
            sum_in += got;
        end
        check("pit inside sum", sum_in, 100);
        sum_out = 0;
        for (int i = 4; i <= 6; i++) begin
            run_frame(pit[i], got);
            sum_out += got;
        end
        check("pit outside sum", sum_out, OUT_SUM_EXP);

        // Reset during MUL: no partial or stale result may survive.
        wait_write("rst_mid");
        drive(tbl[4]);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid write", int'(write), 1);
        check("rst_mid area", int'(area), 0);
        rst = 1'b0;
        run_frame(tbl[0], got);

        // Randomized frames against the arithmetic model.
        for (int i = 0; i < 20; i++) begin
            v.x1 = rnd_coord(); v.y1 = rnd_coord();
            v.x2 = rnd_coord(); v.y2 = rnd_coord();
            v.x3 = rnd_coord(); v.y3 = rnd_coord();
            v.exp  = ref_area(v.x1, v.y1, v.x2, v.y2, v.x3, v.y3);
            v.name = "random";
            run_frame(v, got);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
